tlv493_poller: RTL
==================

Name: tlv493_poller

Overview:
Multi-channel autonomous poller for TLV493 3D Hall sensors. Drives one transaction-level I2C master per sweep slot, and decodes the 7-byte measurement frames into sign-extended registers. Checks frame counters, counts NACK, frame and timeout errors per channel, and exposes everything on an Avalon-MM slave. Sits between the Avalon fabric and the per-sensor i2c_master instances, replacing ad-hoc read/parse logic.

Parameters:
NUM_CHANNELS, 4, number of sensors polled round-robin (1..256)
CLOCK_SPEED_HZ, 50_000_000, clock frequency
DEFAULT_PERIOD, 500_000, reset value of sweep period in clock cycles (100 Hz)
MAX_FRAME_ERRORS, 3, consecutive frame-counter mismatches before a channel is flagged stale
TIMEOUT_CYCLES, 100_000, cycles allowed from txn_req rise to txn_done

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  16  [15:8] register select, [7:0] channel index
read  in  1  Avalon read
readdata  out  32  Avalon read data
write  in  1  Avalon write
writedata  in  32  Avalon write data
waitrequest  out  1  Avalon wait
txn_req  out  1  request a 7-byte read of addr 0x5E on channel txn_ch
txn_ch  out  max(1,$clog2(NUM_CHANNELS))  channel of current transaction
txn_byte_valid  in  1  one received byte present
txn_byte  in  8  received byte, in bus order
txn_done  in  1  one-cycle pulse, transaction finished
txn_ack_error  in  1  qualifies txn_done: NACK occurred
resync_req  out  NUM_CHANNELS  one-cycle pulse per channel requesting a general reset/reconfigure

Behaviour:
- Reset values: readdata=0, waitrequest=0, txn_req=0, txn_ch=0, resync_req=0, all data/counters 0, enable=0, period=DEFAULT_PERIOD.
- Avalon read: 1 wait state. waitrequest=1 in the first cycle of read; readdata is registered and valid in the next cycle, with waitrequest=0. Writes have no wait state.
- Per-channel read map (reg, ch < NUM_CHANNELS; else 0):
  - 0x00/0x01/0x02: Bx/By/Bz, 12-bit sign-extended to 32.
  - 0x03: temp, 12-bit zero-extended.
  - 0x04: {24'b0, stale, T, FF, PD, frm[1:0], ch[1:0]}.
  - 0x05: NACK count. 0x06: frame-error count. 0x07: good-sample count.
  - All counters 16-bit, saturating, zero-extended.
- Global map (channel field ignored):
  - 0x80 ctrl R/W: bit0 enable, bit1 single-shot (write-1 pulse, reads 0).
  - 0x81 period R/W; 0 disables periodic sweeps.
  - 0x82 W: any value clears all counters and stale flags.
  - 0x83 R: {busy, overrun}. overrun is sticky and cleared by writing 0x82.
  - Unmapped reads return 0; unmapped writes are ignored.
- Period counter: counts down from period while enable=1 and period!=0, pulses a tick at 0, then reloads. A tick or single-shot while a sweep is active sets overrun and is dropped.
- FSM:
  - IDLE: on tick or single-shot go to ISSUE with ch=0.
  - ISSUE: txn_req<=1, byte index<=0, timeout counter loaded. Go to WAIT.
  - WAIT: txn_req and txn_ch held stable. On each txn_byte_valid, store byte[index] if index<7 and increment index; extra bytes are ignored. On txn_done, or timeout expiry (treated as NACK), txn_req<=0 and go to CHECK.
  - CHECK: one cycle, then go to ISSUE for ch+1, or to IDLE after ch=NUM_CHANNELS-1.
- CHECK rules:
  - NACK, timeout, or fewer than 7 bytes: NACK count +1; data registers unchanged.
  - Else decode:
    - Bx={b0,b4[7:4]}; By={b1,b4[3:0]}; Bz={b2,b5[3:0]}; temp={b3[7:4],b6}.
    - frm=b3[3:2]; ch=b3[1:0]; T=b5[6]; FF=b5[5]; PD=b5[4].
    - Update data registers and status; good count +1.
  - Frame check (skipped on the first good frame after reset/clear): frm must equal (previous frm+1) mod 4.
    - Mismatch: frame-error count +1, consecutive-error counter +1.
    - Match: consecutive-error counter <= 0.
    - Consecutive-error counter reaching MAX_FRAME_ERRORS: stale<=1, resync_req[ch] pulses once, consecutive-error counter <= 0, frame check re-armed (next frame accepted as baseline).
- Simultaneous Avalon clear (0x82) and CHECK update of the same counter: clear wins.
- enable=0 mid-sweep: current sweep completes; no new ticks.
- Asynchronous reset mid-transaction: txn_req drops immediately and all state returns to reset values.

Optional Feature:
TLV493_TIMESTAMP_EN:
- Defined: a 32-bit free-running cycle counter is latched per channel at each good decode and is readable at reg 0x08.
- Undefined: no counter or storage; reg 0x08 reads 0.

Test Plan:
- Write 0x80=1, 0x81=1000, NUM_CHANNELS=4. Feed good frames -> txn_req/txn_ch 0,1,2,3 every 1000 cycles; first read asserts waitrequest exactly one cycle.
- Bytes 0x80,0x7F,0x01,0x34,0xF5,0x5A,0x12 -> Bx=0xFFFFF80F, By=0x7F5, Bz=0x01A, temp=0x312, frm=1, ch=0, T=1, FF=0, PD=1.
- txn_done with txn_ack_error=1 on ch2 -> reg 0x05 ch2 = 1; ch2 data unchanged; ch2 good count unchanged.
- frm sequence 0,1,3,3,3 on ch1 (MAX_FRAME_ERRORS=3) -> frame errors=3, stale=1, a single resync_req[1] pulse.
- Withhold txn_done for TIMEOUT_CYCLES -> txn_req drops, NACK count +1, sweep proceeds to next channel.
- period=10 with slow sweep -> 0x83 overrun=1; write 0x82 -> all counters and overrun read 0.

Source files
------------

// File: rtl/tlv493_poller.sv
// tlv493_poller: round-robin TLV493 poller, 7-byte frame decode, error tracking, Avalon-MM register map.
// Optional macro TLV493_TIMESTAMP_EN: per-channel 32-bit cycle timestamp at reg 0x08.
module tlv493_poller #(
  parameter int NUM_CHANNELS = 4,
  parameter int CLOCK_SPEED_HZ = 50_000_000,
  parameter int DEFAULT_PERIOD = CLOCK_SPEED_HZ / 100,
  parameter int MAX_FRAME_ERRORS = 3,
  parameter int TIMEOUT_CYCLES = 100_000,
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             address,
  input  logic                    read,
  output logic [31:0]             readdata,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic                    waitrequest,
  output logic                    txn_req,
  output logic [CW-1:0]           txn_ch,
  input  logic                    txn_byte_valid,
  input  logic [7:0]              txn_byte,
  input  logic                    txn_done,
  input  logic                    txn_ack_error,
  output logic [NUM_CHANNELS-1:0] resync_req
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;
  state_t state;
  logic [2:0] idx;
  logic [31:0] tmo, period, cnt, rmux;
  logic nack, enable, overrun, rd_done, tick, shot, clr, start, good, last, cv;
  logic [7:0] sel;
  logic [CW-1:0] ci;
  logic [7:0] b [7];
  logic [11:0] bx [NUM_CHANNELS];
  logic [11:0] by [NUM_CHANNELS];
  logic [11:0] bz [NUM_CHANNELS];
  logic [11:0] tmp [NUM_CHANNELS];
  logic [6:0] stat [NUM_CHANNELS];
  logic [1:0] prev [NUM_CHANNELS];
  logic stale [NUM_CHANNELS];
  logic armed [NUM_CHANNELS];
  logic [15:0] nack_cnt [NUM_CHANNELS];
  logic [15:0] ferr_cnt [NUM_CHANNELS];
  logic [15:0] good_cnt [NUM_CHANNELS];
  logic [15:0] cons [NUM_CHANNELS];
`ifdef TLV493_TIMESTAMP_EN
  logic [31:0] cyc;
  logic [31:0] ts [NUM_CHANNELS];
  always_ff @(posedge clock or posedge reset)
    if (reset) cyc <= '0;
    else cyc <= cyc + 32'd1;
`endif

  function automatic logic [15:0] sat(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  assign sel = address[15:8];
  assign ci = address[CW-1:0];
  assign cv = 32'(address[7:0]) < NUM_CHANNELS;
  assign tick = enable && period != '0 && cnt == '0;
  assign shot = write && sel == 8'h80 && writedata[1];
  assign clr = write && sel == 8'h82;
  assign start = tick || shot;
  assign waitrequest = read && !rd_done;
  assign good = !nack && idx == 3'd7;
  assign last = txn_ch == CW'(NUM_CHANNELS - 1);

  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (!enable || period == '0 || cnt == '0) cnt <= period - 32'd1;
    else cnt <= cnt - 32'd1;

  always_comb begin
    rmux = '0;
    case (sel)
      8'h00: rmux = {{20{bx[ci][11]}}, bx[ci]};
      8'h01: rmux = {{20{by[ci][11]}}, by[ci]};
      8'h02: rmux = {{20{bz[ci][11]}}, bz[ci]};
      8'h03: rmux = {20'd0, tmp[ci]};
      8'h04: rmux = {24'd0, stale[ci], stat[ci]};
      8'h05: rmux = {16'd0, nack_cnt[ci]};
      8'h06: rmux = {16'd0, ferr_cnt[ci]};
      8'h07: rmux = {16'd0, good_cnt[ci]};
`ifdef TLV493_TIMESTAMP_EN
      8'h08: rmux = ts[ci];
`endif
      8'h80: rmux = {31'd0, enable};
      8'h81: rmux = period;
      8'h83: rmux = {30'd0, state != IDLE, overrun};
      default: rmux = '0;
    endcase
    if (sel < 8'h80 && !cv) rmux = '0;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_done <= 1'b0;
      readdata <= '0;
    end else begin
      rd_done <= read && !rd_done;
      if (read && !rd_done) readdata <= rmux;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      txn_req <= 1'b0;
      txn_ch <= '0;
      resync_req <= '0;
      idx <= '0;
      tmo <= '0;
      nack <= 1'b0;
      enable <= 1'b0;
      period <= 32'(DEFAULT_PERIOD);
      overrun <= 1'b0;
      for (int i = 0; i < 7; i++) b[i] <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
        bz[i] <= '0;
        tmp[i] <= '0;
        stat[i] <= '0;
        prev[i] <= '0;
        stale[i] <= 1'b0;
        armed[i] <= 1'b0;
        nack_cnt[i] <= '0;
        ferr_cnt[i] <= '0;
        good_cnt[i] <= '0;
        cons[i] <= '0;
`ifdef TLV493_TIMESTAMP_EN
        ts[i] <= '0;
`endif
      end
    end else begin
      resync_req <= '0;
      if (write && sel == 8'h80) enable <= writedata[0];
      if (write && sel == 8'h81) period <= writedata;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          txn_ch <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          txn_req <= 1'b1;
          idx <= '0;
          nack <= 1'b0;
          tmo <= 32'(TIMEOUT_CYCLES - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (txn_byte_valid && idx != 3'd7) begin
            b[idx] <= txn_byte;
            idx <= idx + 3'd1;
          end
          if (txn_done || tmo == '0) begin
            txn_req <= 1'b0;
            nack <= txn_done ? txn_ack_error : 1'b1;
            state <= CHECK;
          end else tmo <= tmo - 32'd1;
        end
        CHECK: begin
          if (!good) nack_cnt[txn_ch] <= sat(nack_cnt[txn_ch]);
          else begin
            bx[txn_ch] <= {b[0], b[4][7:4]};
            by[txn_ch] <= {b[1], b[4][3:0]};
            bz[txn_ch] <= {b[2], b[5][3:0]};
            tmp[txn_ch] <= {b[3][7:4], b[6]};
            stat[txn_ch] <= {b[5][6:4], b[3][3:0]};
            prev[txn_ch] <= b[3][3:2];
            good_cnt[txn_ch] <= sat(good_cnt[txn_ch]);
`ifdef TLV493_TIMESTAMP_EN
            ts[txn_ch] <= cyc;
`endif
            // first frame after reset/clear/resync only establishes the counter baseline
            if (!armed[txn_ch]) armed[txn_ch] <= 1'b1;
            else if (b[3][3:2] == prev[txn_ch] + 2'd1) cons[txn_ch] <= '0;
            else begin
              ferr_cnt[txn_ch] <= sat(ferr_cnt[txn_ch]);
              if (cons[txn_ch] + 16'd1 >= 16'(MAX_FRAME_ERRORS)) begin
                stale[txn_ch] <= 1'b1;
                resync_req[txn_ch] <= 1'b1;
                cons[txn_ch] <= '0;
                armed[txn_ch] <= 1'b0;
              end else cons[txn_ch] <= cons[txn_ch] + 16'd1;
            end
          end
          txn_ch <= last ? '0 : txn_ch + CW'(1);
          state <= last ? IDLE : ISSUE;
        end
        default: state <= IDLE;
      endcase
      // placed after the CHECK updates so a concurrent clear takes precedence
      if (clr) begin
        overrun <= 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          nack_cnt[i] <= '0;
          ferr_cnt[i] <= '0;
          good_cnt[i] <= '0;
          cons[i] <= '0;
          stale[i] <= 1'b0;
          armed[i] <= 1'b0;
        end
      end
    end
endmodule
